// File: rtl/rid_reorder_return.sv
// rid_reorder_return
//
// Response-side partner of the AR-path ID allocator. Single-beat R responses
// arrive tagged with an internal unique ID {row, col}; each one is parked in
// its own slot. Responses leave in allocation order within a row (one row per
// original ARID), with the original ID restored by the allocator's lookup.
// The allocator's slot is released through free_req as each slot drains.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   downstream R beat handshake (ready is 1 outside reset)
//   in_uid              internal ID {row,col} of the incoming beat
//   in_data/in_resp     RDATA / RRESP of the incoming beat
//   out_valid/out_ready upstream R handshake
//   out_id              restored original RID
//   out_data/out_resp   RDATA / RRESP released upstream
//   out_last            always 1 (single-beat responses)
//   free_req            one-cycle free pulse to the allocator
//   free_unique_id      slot being freed
//   restored_id         allocator's combinational lookup, valid while free_req=1
//   err_dup             sticky flag: a beat arrived for an already-full slot

module rid_reorder_return #(
    parameter int ID_WIDTH = 4,
    parameter int NUM_ROWS = 4,
    parameter int NUM_COLS = 4,
    parameter int DATA_W   = 32,
    parameter int RESP_W   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [((NUM_ROWS>1)?$clog2(NUM_ROWS):1)+((NUM_COLS>1)?$clog2(NUM_COLS):1)-1:0] in_uid,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [RESP_W-1:0]   in_resp,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ID_WIDTH-1:0] out_id,
    output logic [DATA_W-1:0]   out_data,
    output logic [RESP_W-1:0]   out_resp,
    output logic                out_last,
    output logic                free_req,
    output logic [((NUM_ROWS>1)?$clog2(NUM_ROWS):1)+((NUM_COLS>1)?$clog2(NUM_COLS):1)-1:0] free_unique_id,
    input  logic [ID_WIDTH-1:0] restored_id,
    output logic                err_dup
);

    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int UID_W = ROW_W + COL_W;

    logic [ROW_W-1:0]  in_row;
    logic [COL_W-1:0]  in_col;

    logic [NUM_COLS-1:0] slot_valid [NUM_ROWS];
    logic [DATA_W-1:0]   slot_data  [NUM_ROWS][NUM_COLS];
    logic [RESP_W-1:0]   slot_resp  [NUM_ROWS][NUM_COLS];
    logic [COL_W-1:0]    head_col   [NUM_ROWS];
    logic [ROW_W-1:0]    rr_ptr;

    logic [NUM_ROWS-1:0] row_elig;
    logic                any_elig;
    logic [ROW_W-1:0]    sel_row;
    logic [COL_W-1:0]    sel_col;
    logic                load;
    int                  arb_idx;
    logic [ROW_W-1:0]    arb_row;

    assign in_row   = in_uid[UID_W-1:COL_W];
    assign in_col   = in_uid[COL_W-1:0];
    assign in_ready = ~rst;
    assign out_last = 1'b1;

    // A row may release only when the slot at its head pointer is filled;
    // this uses registered state only, so a beat is never bypassed straight
    // from the input to the output register.
    always_comb begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            row_elig[r] = slot_valid[r][head_col[r]];
        end
    end

    // Round-robin pick: first eligible row at or after rr_ptr, with wrap.
    always_comb begin
        any_elig = 1'b0;
        sel_row  = '0;
        arb_idx  = 0;
        arb_row  = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            arb_idx = int'(rr_ptr) + i;
            if (arb_idx >= NUM_ROWS) begin
                arb_idx = arb_idx - NUM_ROWS;
            end
            arb_row = ROW_W'(arb_idx);
            if (!any_elig && row_elig[arb_row]) begin
                any_elig = 1'b1;
                sel_row  = arb_row;
            end
        end
    end

    assign sel_col = head_col[sel_row];
    assign load    = any_elig && (!out_valid || out_ready);

    // The free pulse coincides with the load so that the allocator's
    // restored_id lookup is valid exactly when it is sampled into out_id.
    assign free_req       = load && !rst;
    assign free_unique_id = free_req ? {sel_row, sel_col} : '0;

    // Control state: slot occupancy, head pointers, arbiter pointer and the
    // output register. A capture into an occupied slot is dropped and flagged;
    // the load-side clear is written last so it wins on the drained slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                slot_valid[r] <= '0;
                head_col[r]   <= '0;
            end
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_data  <= '0;
            out_resp  <= '0;
            err_dup   <= 1'b0;
        end else begin
            if (in_valid) begin
                if (slot_valid[in_row][in_col]) begin
                    err_dup <= 1'b1;
                end else begin
                    slot_valid[in_row][in_col] <= 1'b1;
                end
            end
            if (load) begin
                slot_valid[sel_row][sel_col] <= 1'b0;
                head_col[sel_row] <= (sel_col == COL_W'(NUM_COLS - 1)) ? '0 : sel_col + COL_W'(1);
                rr_ptr    <= (sel_row == ROW_W'(NUM_ROWS - 1)) ? '0 : sel_row + ROW_W'(1);
                out_valid <= 1'b1;
                out_id    <= restored_id;
                out_data  <= slot_data[sel_row][sel_col];
                out_resp  <= slot_resp[sel_row][sel_col];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Payload storage needs no reset: slot_valid alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (!rst && in_valid && !slot_valid[in_row][in_col]) begin
            slot_data[in_row][in_col] <= in_data;
            slot_resp[in_row][in_col] <= in_resp;
        end
    end

endmodule

// File: doc/rid_reorder_return.md
Name: rid_reorder_return

Overview:
- Response-side counterpart of the AR-path ID allocator/tag map.
- Accepts single-beat R responses from the downstream slave, tagged with the internal unique ID {row, col}, and buffers each in its dedicated slot.
- Releases responses to the upstream master in allocation order within each row (one row = one original ARID), with the original ARID restored.
- Issues the free request to the allocator as each slot is drained.

Parameters:
- ID_WIDTH, 4, external ARID/RID width.
- NUM_ROWS, 4, allocator rows (distinct concurrent original IDs).
- NUM_COLS, 4, slots per row (outstanding requests per ID).
- DATA_W, 32, RDATA width.
- RESP_W, 2, RRESP width.
- ROW_W, (NUM_ROWS>1)?$clog2(NUM_ROWS):1, derived.
- COL_W, (NUM_COLS>1)?$clog2(NUM_COLS):1, derived.
- UID_W, ROW_W+COL_W, derived.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  downstream R beat valid.
- in_ready  out  1  always 1 outside reset; every uid owns a dedicated slot.
- in_uid  in  UID_W  internal ID {row,col} of the beat.
- in_data  in  DATA_W  RDATA.
- in_resp  in  RESP_W  RRESP.
- out_valid  out  1  upstream R valid.
- out_ready  in  1  upstream R ready.
- out_id  out  ID_WIDTH  restored original RID.
- out_data  out  DATA_W  RDATA.
- out_resp  out  RESP_W  RRESP.
- out_last  out  1  constant 1 (single-beat responses).
- free_req  out  1  one-cycle free pulse to the allocator.
- free_unique_id  out  UID_W  slot being freed.
- restored_id  in  ID_WIDTH  allocator's combinational lookup, valid while free_req=1.
- err_dup  out  1  sticky: a beat arrived for a slot that was already full.

Behaviour:
- State:
  - slot_valid[NUM_ROWS][NUM_COLS]; slot_data and slot_resp per slot.
  - head_col[NUM_ROWS]: per-row release pointer, wraps NUM_COLS-1 -> 0, mirroring the allocator's monotonic column pointer.
  - rr_ptr: round-robin row pointer, ROW_W bits.
  - Output register: out_valid, out_id, out_data, out_resp.
- Reset:
  - All slot_valid=0, head_col=0, rr_ptr=0.
  - out_valid=0, out_id/out_data/out_resp=0.
  - free_req=0, free_unique_id=0, err_dup=0.
  - in_ready=0 while rst=1.
  - Reset mid-operation discards all buffered beats and the output register contents.
- Capture:
  - When in_valid, the slot at {row,col}=in_uid is written with data/resp and slot_valid is set; it is visible the next cycle.
  - If that slot is already valid: the write is dropped, the existing contents are kept, and err_dup is set until reset.
- Eligibility: row r is eligible when slot_valid[r][head_col[r]]=1, using registered state only (no same-cycle bypass from the input).
- Arbitration: pick the first eligible row starting at rr_ptr, searching upward with wrap.
- Load condition: load = (any eligible) && (!out_valid || out_ready).
- On load in cycle T (all in the same cycle T):
  - free_req=1 and free_unique_id={r, head_col[r]}, both combinational.
  - restored_id is sampled into out_id; slot data/resp are sampled into out_data/out_resp.
  - out_valid is set at T+1.
  - slot_valid[r][head_col[r]] is cleared.
  - head_col[r] advances with wrap.
  - rr_ptr becomes r+1, wrapping.
- Output handshake:
  - out_valid holds with stable payload until out_ready.
  - Back-to-back: when out_valid && out_ready and another row is eligible, the register reloads in the same cycle, giving one beat per cycle.
  - With no new load, out_ready clears out_valid.
- Simultaneous events:
  - A capture into the slot being loaded in the same cycle is a duplicate-free impossibility: the loaded slot is already valid, so it flags err_dup and the clear wins.
  - A capture into any other slot proceeds normally.
- Latency: minimum 2 cycles from in_valid to out_valid (capture edge, then load edge).
- Ordering:
  - Within a row, strictly in head_col order.
  - A later column waits for an earlier column even if the later one has arrived.
  - Across rows, no ordering guarantee; round-robin prevents starvation.
- Full condition: all NUM_ROWS*NUM_COLS slots may be valid at once; in_ready stays 1 regardless.

Test Plan:
1. Single response: beat uid {1,0}, data 0xA5A5_0001, resp 0, with restored_id=0x7 during free_req.
   - Free_req pulses with free_unique_id=0x4.
   - Out_valid rises 2 cycles after in_valid with out_id=0x7, out_data=0xA5A5_0001, out_last=1.
2. In-row reorder: beats {2,1} then {2,0} on consecutive cycles.
   - Nothing is released until {2,0} arrives.
   - Output order is {2,0} then {2,1}, back-to-back; head_col[2] ends at 2.
3. Wrap: 6 sequential responses to row 0 (cols 0,1,2,3,0,1), each drained before the next.
   - All are released in order; head_col[0] wraps 3 -> 0 and ends at 2.
4. Back-pressure and fairness: rows 0, 1 and 3 each have a head beat ready, with out_ready=0 for 5 cycles.
   - Out_valid is held with stable payload and only one free_req is issued.
   - After out_ready=1, the order is row 0, row 1, row 3, one per cycle.
5. Duplicate: two beats to uid {3,2} with no drain in between.
   - Err_dup=1 from the cycle after the second beat; the released data equals the first beat.
6. Reset mid-operation: 3 beats buffered with out_valid=1, then rst for 1 cycle.
   - Out_valid=0, no free_req, err_dup=0.
   - A fresh beat to {0,0} is released normally afterward.
